utf8_stream_decoder: RTL and testbench

UTF8_STREAM_DECODER -- requirements
Module: utf8_stream_decoder

---
 rtl/utf8_stream_decoder.sv | 193 +++++++++++++++++++
 tb/tb_utf8_stream_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/utf8_stream_decoder.sv
// utf8_stream_decoder: validating UTF-8 byte stream to code point decoder.
// Rejects surrogates, overlongs and values above 10FFFF; one-entry output register.
// Ports: clk, rst_in (async, active-low), din/din_valid/din_ready byte input,
//   flush (end of stream), cp_out/cp_len/cp_error/cp_valid/cp_ready output,
//   err_count (saturating count of error outputs).
// Build option: UTF8_DEC_REPLACE_EN makes error outputs carry U+FFFD
//   instead of the offending lead byte.
module utf8_stream_decoder (
  input  logic        clk,
  input  logic        rst_in,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        flush,
  output logic [20:0] cp_out,
  output logic [2:0]  cp_len,
  output logic        cp_error,
  output logic        cp_valid,
  input  logic        cp_ready,
  output logic [7:0]  err_count
);

  typedef enum logic {IDLE, CONT} state_t;

  state_t      state;
  logic [20:0] part;
  logic [1:0]  rem;
  logic [7:0]  lead;
  logic [2:0]  taken;

  logic        slot_free;
  logic        reject;
  logic [7:0]  lo;
  logic [7:0]  hi;

  logic [1:0]  l_need;
  logic [20:0] l_bits;
  logic        l_bad;

  logic        emit;
  logic [20:0] e_cp;
  logic [2:0]  e_len;
  logic        e_err;
  logic        to_idle;
  logic        to_cont;
  logic        append;
  logic [20:0] app_val;

  function automatic logic [20:0] err_val(input logic [7:0] b);
`ifdef UTF8_DEC_REPLACE_EN
    err_val = 21'h00FFFD;
`else
    err_val = {13'd0, b};
`endif
  endfunction

  assign slot_free = ~cp_valid | cp_ready;
  assign app_val   = {part[14:0], din[5:0]};

  // Second byte of E0/ED/F0/F4 has a narrowed range; this is
  // what excludes overlongs, surrogates and values above 10FFFF.
  always_comb begin
    lo = 8'h80;
    hi = 8'hBF;
    if (taken == 3'd1) begin
      case (lead)
        8'hE0:   lo = 8'hA0;
        8'hED:   hi = 8'h9F;
        8'hF0:   lo = 8'h90;
        8'hF4:   hi = 8'h8F;
        default: ;
      endcase
    end
  end

  assign reject = (state == CONT) & ((din < lo) | (din > hi));
  assign din_ready = slot_free & ~flush & ~reject;

  always_comb begin
    l_need = 2'd0;
    l_bits = 21'd0;
    l_bad  = 1'b0;
    unique case (1'b1)
      (din <= 8'h7F): l_bits = {13'd0, din};
      (din >= 8'hC2 && din <= 8'hDF): begin
        l_need = 2'd1;
        l_bits = {16'd0, din[4:0]};
      end
      (din >= 8'hE0 && din <= 8'hEF): begin
        l_need = 2'd2;
        l_bits = {17'd0, din[3:0]};
      end
      (din >= 8'hF0 && din <= 8'hF4): begin
        l_need = 2'd3;
        l_bits = {18'd0, din[2:0]};
      end
      default: l_bad = 1'b1;
    endcase
  end

  // flush wins over din; a rejected byte is left on din for IDLE.
  always_comb begin
    emit    = 1'b0;
    e_cp    = 21'd0;
    e_len   = 3'd0;
    e_err   = 1'b0;
    to_idle = 1'b0;
    to_cont = 1'b0;
    append  = 1'b0;
    if (slot_free) begin
      if (flush) begin
        if (state == CONT) begin
          emit    = 1'b1;
          e_cp    = err_val(lead);
          e_len   = taken;
          e_err   = 1'b1;
          to_idle = 1'b1;
        end
      end else if (din_valid) begin
        if (state == IDLE) begin
          if (l_bad) begin
            emit  = 1'b1;
            e_cp  = err_val(din);
            e_len = 3'd1;
            e_err = 1'b1;
          end else if (l_need == 2'd0) begin
            emit  = 1'b1;
            e_cp  = l_bits;
            e_len = 3'd1;
          end else begin
            to_cont = 1'b1;
          end
        end else if (reject) begin
          emit    = 1'b1;
          e_cp    = err_val(lead);
          e_len   = taken;
          e_err   = 1'b1;
          to_idle = 1'b1;
        end else if (rem == 2'd1) begin
          emit    = 1'b1;
          e_cp    = app_val;
          e_len   = taken + 3'd1;
          to_idle = 1'b1;
        end else begin
          append = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      part      <= 21'd0;
      rem       <= 2'd0;
      lead      <= 8'd0;
      taken     <= 3'd0;
      cp_out    <= 21'd0;
      cp_len    <= 3'd0;
      cp_error  <= 1'b0;
      cp_valid  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (cp_valid && cp_ready) cp_valid <= 1'b0;
      if (emit) begin
        cp_valid <= 1'b1;
        cp_out   <= e_cp;
        cp_len   <= e_len;
        cp_error <= e_err;
        if (e_err && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
      if (to_idle) begin
        state <= IDLE;
        part  <= 21'd0;
        rem   <= 2'd0;
        lead  <= 8'd0;
        taken <= 3'd0;
      end else if (to_cont) begin
        state <= CONT;
        part  <= l_bits;
        rem   <= l_need;
        lead  <= din;
        taken <= 3'd1;
      end else if (append) begin
        part  <= app_val;
        rem   <= rem - 2'd1;
        taken <= taken + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// tb_utf8_stream_decoder: directed bench for utf8_stream_decoder.
// Outputs are collected on negedge handshakes and compared in order.
module tb_utf8_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        flush;
  logic [20:0] cp_out;
  logic [2:0]  cp_len;
  logic        cp_error;
  logic        cp_valid;
  logic        cp_ready;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [20:0] cp;
    logic [2:0]  len;
    logic        err;
  } out_t;

  out_t q[$];

  always #5 clk = ~clk;

  utf8_stream_decoder dut (
    .clk(clk),
    .rst_in(rst_in),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .flush(flush),
    .cp_out(cp_out),
    .cp_len(cp_len),
    .cp_error(cp_error),
    .cp_valid(cp_valid),
    .cp_ready(cp_ready),
    .err_count(err_count)
  );

  always @(negedge clk)
    if (rst_in && cp_valid && cp_ready)
      q.push_back('{cp_out, cp_len, cp_error});

  function automatic logic [20:0] ev(input logic [7:0] b);
`ifdef UTF8_DEC_REPLACE_EN
    ev = 21'h00FFFD;
`else
    ev = {13'd0, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    din = b;
    din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (din_ready) acc = 1'b1;
      step();
      if (acc) break;
    end
    din_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [20:0] cp,
                            input logic [2:0] len, input logic err);
    out_t o;
    chk({tag, ":avail"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      o = q.pop_front();
      chk(tag, {7'd0, o}, {7'd0, cp, len, err});
    end
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic none_left(input string tag);
    chk({tag, ":empty"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    rst_in = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;
    flush = 1'b0;
    cp_ready = 1'b1;
    repeat (2) step();
    chk("rst_valid", 32'(cp_valid), 32'd0);
    chk("rst_out", 32'(cp_out), 32'd0);
    chk("rst_len", 32'(cp_len), 32'd0);
    chk("rst_err", 32'(cp_error), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    rst_in = 1'b1;
    step();

    push(8'hE2);
    push(8'h82);
    chk("euro_pre", 32'(cp_valid), 32'd0);
    push(8'hAC);
    chk("euro_lat", 32'(cp_valid), 32'd1);
    drain();
    expect_out("euro", 21'h020AC, 3'd3, 1'b0);
    none_left("euro");

    push(8'hF0);
    push(8'h9F);
    push(8'h98);
    push(8'h80);
    drain();
    expect_out("smile", 21'h1F600, 3'd4, 1'b0);
    none_left("smile");

    push(8'hF4);
    push(8'h90);
    drain();
    expect_out("f4_90_a", ev(8'hF4), 3'd1, 1'b1);
    expect_out("f4_90_b", ev(8'h90), 3'd1, 1'b1);
    none_left("f4_90");
    chk("cnt_2", 32'(err_count), 32'd2);

    push(8'hED);
    push(8'hA0);
    push(8'h80);
    drain();
    expect_out("surr_a", ev(8'hED), 3'd1, 1'b1);
    expect_out("surr_b", ev(8'hA0), 3'd1, 1'b1);
    expect_out("surr_c", ev(8'h80), 3'd1, 1'b1);
    none_left("surr");
    chk("cnt_5", 32'(err_count), 32'd5);

    push(8'hC3);
    din = 8'h41;
    din_valid = 1'b1;
    @(negedge clk);
    chk("c3_41_rdy", 32'(din_ready), 32'd0);
    step();
    push(8'h41);
    drain();
    expect_out("c3_41_a", ev(8'hC3), 3'd1, 1'b1);
    expect_out("c3_41_b", 21'h00041, 3'd1, 1'b0);
    none_left("c3_41");

    cp_ready = 1'b0;
    push(8'h41);
    din = 8'h42;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(din_ready), 32'd0);
      chk("bp_hold", {10'd0, cp_valid, cp_out}, {10'd0, 1'b1, 21'h41});
      step();
    end
    cp_ready = 1'b1;
    push(8'h42);
    drain();
    expect_out("bp_a", 21'h00041, 3'd1, 1'b0);
    expect_out("bp_b", 21'h00042, 3'd1, 1'b0);
    none_left("bp");

    push(8'hE2);
    push(8'h82);
    din = 8'h41;
    din_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy", 32'(din_ready), 32'd0);
    step();
    flush = 1'b0;
    din_valid = 1'b0;
    drain();
    expect_out("flush", ev(8'hE2), 3'd2, 1'b1);
    none_left("flush");
    chk("cnt_7", 32'(err_count), 32'd7);

    push(8'hE2);
    #2;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cp_valid), 32'd0);
    chk("mid_rst_cnt", 32'(err_count), 32'd0);
    step();
    rst_in = 1'b1;
    step();
    push(8'h41);
    drain();
    expect_out("post_rst", 21'h00041, 3'd1, 1'b0);
    none_left("post_rst");
    chk("post_rst_cnt", 32'(err_count), 32'd0);

    push(8'hF4);
    push(8'h8F);
    push(8'hBF);
    push(8'hBF);
    push(8'hE0);
    push(8'hA0);
    push(8'h80);
    push(8'hDF);
    push(8'hBF);
    push(8'h7F);
    push(8'hE0);
    push(8'h9F);
    push(8'hC1);
    drain();
    expect_out("max", 21'h10FFFF, 3'd4, 1'b0);
    expect_out("e0_min", 21'h00800, 3'd3, 1'b0);
    expect_out("two_max", 21'h007FF, 3'd2, 1'b0);
    expect_out("ascii_max", 21'h0007F, 3'd1, 1'b0);
    expect_out("e0_ovl_a", ev(8'hE0), 3'd1, 1'b1);
    expect_out("e0_ovl_b", ev(8'h9F), 3'd1, 1'b1);
    expect_out("c1", ev(8'hC1), 3'd1, 1'b1);
    none_left("bound");
    chk("cnt_3", 32'(err_count), 32'd3);

    for (int i = 0; i < 300; i++) push(8'hFF);
    drain();
    chk("sat_n", 32'(q.size()), 32'd300);
    q.delete();
    chk("sat", 32'(err_count), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
